// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues word-aligned reads to instruction
// memory, captures each response one cycle later into a small circular
// buffer, and presents the buffer head to the decoder. A redirect flushes
// the buffer, drops any in-flight response and restarts fetch.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   buf_instr_q [DEPTH];
  logic [31:0]   buf_pc_q    [DEPTH];

  logic          push;
  logic          pop;
  logic [CW:0]   credit_used;

  // Request credit, handshake and head presentation (head comes from flops only)
  always_comb begin
    credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    imem_req    = !reset && !redirect && (credit_used < DEPTH_W);
    imem_addr   = {fetch_pc_q[31:2], 2'b00};
    instr_valid = !reset && !redirect && (count_q != '0);
    pop         = instr_valid && instr_ready;
    push        = !reset && !redirect && inflight_q;
    instr       = buf_instr_q[head_q];
    instr_pc    = buf_pc_q[head_q];
    count       = reset ? '0 : count_q;
  end

  // Next-state: redirect flushes everything, otherwise advance fetch and buffer
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    req_addr_d = req_addr_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      inflight_d = imem_req;
      if (imem_req) begin
        req_addr_d = imem_addr;
        fetch_pc_d = imem_addr + 32'd4;
      end
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Datapath registers: address of the outstanding request and buffer storage
  always_ff @(posedge clk) begin
    req_addr_q <= req_addr_d;
    if (push) begin
      buf_instr_q[tail_q] <= imem_rdata;
      buf_pc_q[tail_q]    <= req_addr_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue. Memory returns data equal to the address
// of the previous cycle's request, so every delivered instr must equal instr_pc.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  count;

  int passed = 0;
  int total  = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .count       (count)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, data = address
  always @(posedge clk) imem_rdata <= imem_addr;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1ns into cycle 0: first cycle with reset low
  task automatic do_reset(input logic rdy);
    next_cycle();
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = rdy;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", imem_req); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", instr_valid); else passed++;
    total++; if (count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count); else passed++;
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next_cycle();
      #1;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4*c))
        $display("FAIL stream_req c=%0d got req=%b addr=%h exp req=1 addr=%h", c, imem_req, imem_addr, 32'(4*c));
      else passed++;
      total++;
      if (c < 2) begin
        if (instr_valid !== 1'b0) $display("FAIL stream_early_valid c=%0d got=%b exp=0", c, instr_valid); else passed++;
      end else begin
        if (instr_valid !== 1'b1 || instr_pc !== 32'(4*(c-2)) || instr !== 32'(4*(c-2)))
          $display("FAIL stream_head c=%0d got v=%b pc=%h instr=%h exp v=1 pc=%h", c, instr_valid, instr_pc, instr, 32'(4*(c-2)));
        else passed++;
      end
      if (c == 3) begin
        total++; if (count !== 3'd1) $display("FAIL stream_count got=%0d exp=1", count); else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    do_reset(1'b0);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cycle();
      if (c == 7) instr_ready = 1'b1;
      #1;
      if (imem_req === 1'b1) nreq++;
      if (c < 7) begin
        total++;
        if (imem_req !== (c < 4))
          $display("FAIL bp_req c=%0d got=%b exp=%b", c, imem_req, (c < 4));
        else passed++;
      end
      if (c == 6) begin
        total++; if (count !== 3'd4) $display("FAIL bp_full_count got=%0d exp=4", count); else passed++;
        total++; if (nreq != 4) $display("FAIL bp_num_req got=%0d exp=4", nreq); else passed++;
      end
      if (c >= 7) begin
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'(4*(c-7)) || instr !== 32'(4*(c-7)))
          $display("FAIL bp_drain c=%0d got v=%b pc=%h instr=%h exp pc=%h", c, instr_valid, instr_pc, instr, 32'(4*(c-7)));
        else passed++;
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    for (int c = 0; c < 9; c++) begin
      if (c > 0) next_cycle();
      redirect = (c == 4);
      redirect_pc = 32'h0000_2000;
      if (c == 7) instr_ready = 1'b1;
      #1;
      if (c == 4) begin
        total++; if (count !== 3'd3) $display("FAIL rd_pre_count got=%0d exp=3", count); else passed++;
        total++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0)
          $display("FAIL rd_cycle got valid=%b req=%b exp 0/0", instr_valid, imem_req);
        else passed++;
      end
      if (c == 5) begin
        total++; if (count !== 3'd0) $display("FAIL rd_flush_count got=%0d exp=0", count); else passed++;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h2000)
          $display("FAIL rd_new_req got req=%b addr=%h exp 1/00002000", imem_req, imem_addr);
        else passed++;
      end
      if (c == 6) begin
        total++; if (instr_valid !== 1'b0) $display("FAIL rd_no_stale got v=%b pc=%h exp v=0", instr_valid, instr_pc); else passed++;
      end
      if (c >= 7) begin
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h2000 + 32'(4*(c-7)) || instr !== instr_pc)
          $display("FAIL rd_deliver c=%0d got v=%b pc=%h instr=%h exp pc=%h", c, instr_valid, instr_pc, instr, 32'h2000 + 32'(4*(c-7)));
        else passed++;
      end
    end
    redirect = 1'b0;
  endtask

  task automatic test_redirect_target(input logic [31:0] tgt, input logic [31:0] a0, input logic [31:0] a1);
    do_reset(1'b1);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next_cycle();
      redirect    = (c == 3);
      redirect_pc = tgt;
      #1;
      if (c == 4) begin
        total++;
        if (imem_req !== 1'b1 || imem_addr !== a0) $display("FAIL tgt_addr0 got req=%b addr=%h exp %h", imem_req, imem_addr, a0); else passed++;
      end
      if (c == 5) begin
        total++;
        if (imem_addr !== a1 || instr_valid !== 1'b0) $display("FAIL tgt_addr1 got addr=%h v=%b exp %h v=0", imem_addr, instr_valid, a1); else passed++;
      end
      if (c == 6) begin
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== a0 || instr !== a0) $display("FAIL tgt_pc0 got v=%b pc=%h instr=%h exp %h", instr_valid, instr_pc, instr, a0); else passed++;
      end
      if (c == 7) begin
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== a1 || instr !== a1) $display("FAIL tgt_pc1 got v=%b pc=%h instr=%h exp %h", instr_valid, instr_pc, instr, a1); else passed++;
      end
    end
    redirect = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset(1'b0);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next_cycle();
      reset = (c == 3);
      if (c == 5) instr_ready = 1'b1;
      #1;
      if (c == 2) begin
        total++; if (count !== 3'd1) $display("FAIL mr_pre_count got=%0d exp=1", count); else passed++;
      end
      if (c == 3) begin
        total++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || count !== 3'd0)
          $display("FAIL mr_during got req=%b v=%b count=%0d exp 0/0/0", imem_req, instr_valid, count);
        else passed++;
      end
      if (c == 4) begin
        total++;
        if (count !== 3'd0 || instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0)
          $display("FAIL mr_after got count=%0d v=%b req=%b addr=%h exp 0/0/1/0", count, instr_valid, imem_req, imem_addr);
        else passed++;
      end
      if (c == 5) begin
        total++; if (instr_valid !== 1'b0) $display("FAIL mr_no_stale got v=%b pc=%h exp v=0", instr_valid, instr_pc); else passed++;
      end
      if (c >= 6) begin
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'(4*(c-6)) || instr !== 32'(4*(c-6)))
          $display("FAIL mr_deliver c=%0d got v=%b pc=%h instr=%h exp pc=%h", c, instr_valid, instr_pc, instr, 32'(4*(c-6)));
        else passed++;
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_target(32'h0000_2003, 32'h0000_2000, 32'h0000_2004);
    test_redirect_target(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
